// File: rtl/p405s_exepipeifb_if.sv
// Bundle between the PCL/decode side and the execute control pipeline.
// master drives stage-0 sources, enables and flushes; slave is the pipeline.
interface p405s_exepipeifb_if #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 3
);
    logic [WIDTH-1:0]       dcdData;
    logic [WIDTH-1:0]       apuData;
    logic                   APU_dcdValidOp_Neg;
    logic                   dcdValid;
    logic [DEPTH-1:0]       stageE1;
    logic [DEPTH-1:0]       stageE2;
    logic [DEPTH-1:0]       stageFlush;
    logic [DEPTH*WIDTH-1:0] stageData;
    logic [DEPTH-1:0]       stageValid;
    logic [3:0]             validCount;
    logic                   pipeEmpty;
    logic [DEPTH-1:0]       overrunErr;

    modport master (
        output dcdData, apuData, APU_dcdValidOp_Neg, dcdValid,
               stageE1, stageE2, stageFlush,
        input  stageData, stageValid, validCount, pipeEmpty, overrunErr
    );

    modport slave (
        input  dcdData, apuData, APU_dcdValidOp_Neg, dcdValid,
               stageE1, stageE2, stageFlush,
        output stageData, stageValid, validCount, pipeEmpty, overrunErr
    );
endinterface

// File: rtl/p405s_exepipeifb.sv
// Execute-side control pipeline: DEPTH stages of WIDTH bits with per-stage
// valid, flush, stage-0 APU/decode select, occupancy count and sticky overrun.
module p405s_exepipeifb #(
    parameter int unsigned WIDTH         = 24,
    parameter int unsigned DEPTH         = 3,
    parameter bit          FLUSH_ON_HOLD = 1'b1
) (
    input  logic              CB,
    input  logic              syncReset,
    p405s_exepipeifb_if.slave pif
);
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            ovr_q, ovr_d;

    logic [DEPTH:0][WIDTH-1:0]   src_data;
    logic [DEPTH:0]              src_valid;
    logic [DEPTH-1:0]            en, flush_act, capture, next_capture;
    logic [3:0]                  count_c;

    // Next-state: flush beats load beats hold; entry i of src_* feeds stage i.
    always_comb begin
        en           = pif.stageE1 & pif.stageE2;
        flush_act    = pif.stageFlush & (en | {DEPTH{FLUSH_ON_HOLD}});
        capture      = en & ~flush_act;
        // Bit i = "stage i+1 takes stage i's contents"; the last stage always drains.
        next_capture = DEPTH'({1'b1, capture} >> 1);
        src_data     = {data_q, (pif.APU_dcdValidOp_Neg ? pif.dcdData : pif.apuData)};
        src_valid    = {valid_q, pif.dcdValid};

        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush_act[i]) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end else if (en[i]) begin
                data_d[i]  = src_data[i];
                valid_d[i] = src_valid[i];
            end
            if (capture[i] && valid_q[i] && !next_capture[i]) begin
                ovr_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CB) begin
        if (syncReset) begin
            data_q  <= '0;
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Occupancy is derived combinationally from the registered valid bits.
    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_c = count_c + 4'(valid_q[i]);
        end
    end

    assign pif.stageData  = data_q;
    assign pif.stageValid = valid_q;
    assign pif.overrunErr = ovr_q;
    assign pif.validCount = count_c;
    assign pif.pipeEmpty  = (count_c == 4'd0);
endmodule

// File: tb/tb_p405s_exepipeifb.sv
// Bench: table-driven vectors on a default-sized pipe plus hand sequences on a
// DEPTH=5/WIDTH=8 pipe built with FLUSH_ON_HOLD=0; expectations flow through queues.
module tb_p405s_exepipeifb;
    localparam int unsigned AW = 24;
    localparam int unsigned AD = 3;
    localparam int unsigned BW = 8;
    localparam int unsigned BD = 5;
    localparam int          NA = 19;

    logic CB = 1'b0;
    logic syncReset;
    always #5 CB = ~CB;

    p405s_exepipeifb_if #(.WIDTH(AW), .DEPTH(AD)) ifa ();
    p405s_exepipeifb_if #(.WIDTH(BW), .DEPTH(BD)) ifb ();

    p405s_exepipeifb #(.WIDTH(AW), .DEPTH(AD), .FLUSH_ON_HOLD(1'b1)) u_a (
        .CB(CB), .syncReset(syncReset), .pif(ifa)
    );
    p405s_exepipeifb #(.WIDTH(BW), .DEPTH(BD), .FLUSH_ON_HOLD(1'b0)) u_b (
        .CB(CB), .syncReset(syncReset), .pif(ifb)
    );

    typedef struct {
        logic        rst;
        logic [23:0] dcd;
        logic [23:0] apu;
        logic        sel;
        logic        dv;
        logic [2:0]  e1;
        logic [2:0]  e2;
        logic [2:0]  fl;
        logic [71:0] x_data;
        logic [2:0]  x_valid;
        logic [2:0]  x_ovr;
        logic [3:0]  x_cnt;
    } avec_t;

    typedef struct {
        logic [71:0] data;
        logic [7:0]  valid;
        logic [7:0]  ovr;
        logic [3:0]  cnt;
        logic        empty;
    } exp_t;

    avec_t va [NA];
    exp_t  qa [$];
    exp_t  qb [$];
    int    checks = 0;
    int    errors = 0;
    int    peak_b = 0;

    function automatic avec_t mka(logic rst, logic [23:0] dcd, logic [23:0] apu, logic sel,
                                  logic dv, logic [2:0] e1, logic [2:0] e2, logic [2:0] fl,
                                  logic [71:0] xd, logic [2:0] xv, logic [2:0] xo, logic [3:0] xc);
        avec_t v;
        v.rst = rst; v.dcd = dcd; v.apu = apu; v.sel = sel; v.dv = dv;
        v.e1 = e1; v.e2 = e2; v.fl = fl;
        v.x_data = xd; v.x_valid = xv; v.x_ovr = xo; v.x_cnt = xc;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input int step, input exp_t e, input logic [71:0] d,
                       input logic [7:0] v, input logic [7:0] o, input logic [3:0] c, input logic em);
        chk({tag, ".stageData"},  step, d, e.data);
        chk({tag, ".stageValid"}, step, 72'(v), 72'(e.valid));
        chk({tag, ".overrunErr"}, step, 72'(o), 72'(e.ovr));
        chk({tag, ".validCount"}, step, 72'(c), 72'(e.cnt));
        chk({tag, ".pipeEmpty"},  step, 72'(em), 72'(e.empty));
    endtask

    // One DUT-B cycle: drive at negedge, queue expectation, compare after the edge.
    task automatic step_b(input int step, input logic rst, input logic dv, input logic [7:0] dcd,
                          input logic [4:0] en, input logic [4:0] fl,
                          input logic [39:0] xd, input logic [4:0] xv, input logic [3:0] xc);
        exp_t e;
        @(negedge CB);
        syncReset = rst;
        ifb.dcdValid = dv; ifb.dcdData = dcd; ifb.APU_dcdValidOp_Neg = 1'b1; ifb.apuData = 8'hEE;
        ifb.stageE1 = en; ifb.stageE2 = 5'h1F; ifb.stageFlush = fl;
        e.data = 72'(xd); e.valid = 8'(xv); e.ovr = 8'h00; e.cnt = xc; e.empty = (xv == 5'd0);
        qb.push_back(e);
        @(posedge CB);
        #1;
        if (int'(ifb.validCount) > peak_b) peak_b = int'(ifb.validCount);
        if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL B.scoreboard step %0d: got empty queue expected an entry", step);
        end else begin
            e = qb.pop_front();
            cmp("B", step, e, 72'(ifb.stageData), 8'(ifb.stageValid), 8'(ifb.overrunErr),
                ifb.validCount, ifb.pipeEmpty);
        end
    endtask

    initial begin
        exp_t e;
        syncReset = 1'b1;
        ifa.dcdData = '0; ifa.apuData = '0; ifa.APU_dcdValidOp_Neg = 1'b1; ifa.dcdValid = 1'b0;
        ifa.stageE1 = '0; ifa.stageE2 = '0; ifa.stageFlush = '0;
        ifb.dcdData = '0; ifb.apuData = '0; ifb.APU_dcdValidOp_Neg = 1'b1; ifb.dcdValid = 1'b0;
        ifb.stageE1 = '0; ifb.stageE2 = '0; ifb.stageFlush = '0;

        // reset, flow-through of a single op, APU select, overrun, flush cases, reset clear
        va[0]  = mka(1, 24'h0, 24'h0, 0, 0, 3'd0, 3'd0, 3'd0, 72'h0, 3'b000, 3'b000, 4'd0);
        va[1]  = mka(1, 24'h0, 24'h0, 0, 0, 3'd0, 3'd0, 3'd0, 72'h0, 3'b000, 3'b000, 4'd0);
        va[2]  = mka(0, 24'hABCDEF, 24'h0, 1, 1, 3'd7, 3'd7, 3'd0,
                     {24'h0, 24'h0, 24'hABCDEF}, 3'b001, 3'b000, 4'd1);
        va[3]  = mka(0, 24'h0, 24'h0, 1, 0, 3'd7, 3'd7, 3'd0,
                     {24'h0, 24'hABCDEF, 24'h0}, 3'b010, 3'b000, 4'd1);
        va[4]  = mka(0, 24'h0, 24'h0, 1, 0, 3'd7, 3'd7, 3'd0,
                     {24'hABCDEF, 24'h0, 24'h0}, 3'b100, 3'b000, 4'd1);
        va[5]  = mka(0, 24'h0, 24'h0, 1, 0, 3'd7, 3'd7, 3'd0, 72'h0, 3'b000, 3'b000, 4'd0);
        va[6]  = mka(0, 24'hABCDEF, 24'h000123, 0, 1, 3'd7, 3'd1, 3'd0,
                     {24'h0, 24'h0, 24'h000123}, 3'b001, 3'b000, 4'd1);
        va[7]  = mka(0, 24'h111111, 24'h0, 1, 1, 3'd3, 3'd7, 3'd0,
                     {24'h0, 24'h000123, 24'h111111}, 3'b011, 3'b000, 4'd2);
        va[8]  = mka(0, 24'h222222, 24'h0, 1, 1, 3'd3, 3'd7, 3'd0,
                     {24'h0, 24'h111111, 24'h222222}, 3'b011, 3'b010, 4'd2);
        for (int i = 9; i < 14; i++) begin
            va[i] = mka(0, 24'h0, 24'h0, 1, 0, 3'd0, 3'd0, 3'd0,
                        {24'h0, 24'h111111, 24'h222222}, 3'b011, 3'b010, 4'd2);
        end
        va[14] = mka(0, 24'hFFFFFF, 24'h0, 1, 1, 3'd1, 3'd1, 3'd1,
                     {24'h0, 24'h111111, 24'h0}, 3'b010, 3'b010, 4'd1);
        va[15] = mka(0, 24'h5A5A5A, 24'h0, 1, 1, 3'd1, 3'd1, 3'd0,
                     {24'h0, 24'h111111, 24'h5A5A5A}, 3'b011, 3'b010, 4'd2);
        va[16] = mka(0, 24'h0, 24'h0, 1, 0, 3'd2, 3'd2, 3'd0,
                     {24'h0, 24'h5A5A5A, 24'h5A5A5A}, 3'b011, 3'b010, 4'd2);
        va[17] = mka(0, 24'h0, 24'h0, 1, 0, 3'd0, 3'd0, 3'd2,
                     {24'h0, 24'h0, 24'h5A5A5A}, 3'b001, 3'b010, 4'd1);
        va[18] = mka(1, 24'hABCDEF, 24'h0, 1, 1, 3'd7, 3'd7, 3'd0, 72'h0, 3'b000, 3'b000, 4'd0);

        for (int i = 0; i < NA; i++) begin
            @(negedge CB);
            syncReset = va[i].rst;
            ifa.dcdData = va[i].dcd; ifa.apuData = va[i].apu;
            ifa.APU_dcdValidOp_Neg = va[i].sel; ifa.dcdValid = va[i].dv;
            ifa.stageE1 = va[i].e1; ifa.stageE2 = va[i].e2; ifa.stageFlush = va[i].fl;
            e.data = va[i].x_data; e.valid = 8'(va[i].x_valid); e.ovr = 8'(va[i].x_ovr);
            e.cnt = va[i].x_cnt; e.empty = (va[i].x_cnt == 4'd0);
            qa.push_back(e);
            @(posedge CB);
            #1;
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL A.scoreboard step %0d: got empty queue expected an entry", i);
            end else begin
                e = qa.pop_front();
                cmp("A", i, e, 72'(ifa.stageData), 8'(ifa.stageValid), 8'(ifa.overrunErr),
                    ifa.validCount, ifa.pipeEmpty);
            end
        end
        @(negedge CB);
        ifa.stageE1 = '0; ifa.stageE2 = '0; ifa.dcdValid = 1'b0;

        // Bubble between two ops marching through five stages
        step_b(0,  1, 0, 8'h00, 5'h00, 5'h00, 40'h0, 5'b00000, 4'd0);
        step_b(1,  0, 1, 8'h11, 5'h1F, 5'h00, 40'h00_00_00_00_11, 5'b00001, 4'd1);
        step_b(2,  0, 0, 8'h00, 5'h1F, 5'h00, 40'h00_00_00_11_00, 5'b00010, 4'd1);
        step_b(3,  0, 1, 8'h33, 5'h1F, 5'h00, 40'h00_00_11_00_33, 5'b00101, 4'd2);
        step_b(4,  0, 0, 8'h00, 5'h1F, 5'h00, 40'h00_11_00_33_00, 5'b01010, 4'd2);
        step_b(5,  0, 0, 8'h00, 5'h1F, 5'h00, 40'h11_00_33_00_00, 5'b10100, 4'd2);
        step_b(6,  0, 0, 8'h00, 5'h1F, 5'h00, 40'h00_33_00_00_00, 5'b01000, 4'd1);
        step_b(7,  0, 0, 8'h00, 5'h1F, 5'h00, 40'h33_00_00_00_00, 5'b10000, 4'd1);
        step_b(8,  0, 0, 8'h00, 5'h1F, 5'h00, 40'h0, 5'b00000, 4'd0);
        // Flush without enable is ignored here; flush with enable clears without flagging
        step_b(9,  0, 1, 8'h5A, 5'h01, 5'h00, 40'h00_00_00_00_5A, 5'b00001, 4'd1);
        step_b(10, 0, 0, 8'h00, 5'h02, 5'h00, 40'h00_00_00_5A_5A, 5'b00011, 4'd2);
        step_b(11, 0, 0, 8'h00, 5'h00, 5'h02, 40'h00_00_00_5A_5A, 5'b00011, 4'd2);
        step_b(12, 0, 0, 8'h00, 5'h02, 5'h02, 40'h00_00_00_00_5A, 5'b00001, 4'd1);

        chk("B.validCount_peak", 13, 72'(peak_b), 72'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
